// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer; define MULTICYCLE_CTRL_INSTRET_EN for the instret_o counter
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_W      = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [6:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        alu_src_o,
    output logic [1:0]  alu_op_o,
    output logic        mem_to_reg_o,
    output logic        reg_write_o,
    output logic        instr_done_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic        halted_o,
    output logic [2:0]  state_o,
    output logic [31:0] instret_o
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_e;
    typedef enum logic [1:0] {CL_R, CL_LD, CL_ST, CL_BR} class_e;
    state_e               state_q, state_d;
    class_e               class_q, class_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
    logic                 timeout_q, timeout_d;
    logic                 req, we, irw, pcw, pcs, alus, m2r, rw, done, ill, wait_mem, tmo_hit;
    logic [1:0]           aluop;
    always_comb begin
        req = 1'b0;
        we = 1'b0;
        irw = 1'b0;
        pcw = 1'b0;
        pcs = 1'b0;
        alus = 1'b0;
        aluop = 2'b00;
        m2r = 1'b0;
        rw = 1'b0;
        done = 1'b0;
        ill = 1'b0;
        state_d = state_q;
        class_d = class_q;
        case (state_q)
            FETCH: begin
                req = 1'b1;
                irw = mem_ready_i;
                pcw = mem_ready_i;
                state_d = mem_ready_i ? DECODE : FETCH;
            end
            DECODE: begin
                state_d = EXEC;
                case (opcode_i)
                    7'b0110011: class_d = CL_R;
                    7'b0000011: class_d = CL_LD;
                    7'b0100011: class_d = CL_ST;
                    7'b1100011: class_d = CL_BR;
                    default: begin
                        ill = 1'b1;
                        state_d = HALT;
                    end
                endcase
            end
            EXEC: begin
                alus = (class_q == CL_LD) || (class_q == CL_ST);
                aluop = (class_q == CL_R) ? 2'b10 : (class_q == CL_BR) ? 2'b01 : 2'b00;
                pcw = (class_q == CL_BR) && zero_i;
                pcs = (class_q == CL_BR) && zero_i;
                done = class_q == CL_BR;
                state_d = (class_q == CL_R) ? WB : (class_q == CL_BR) ? FETCH : MEM;
            end
            MEM: begin
                req = 1'b1;
                we = class_q == CL_ST;
                alus = 1'b1;
                done = mem_ready_i && (class_q == CL_ST);
                state_d = !mem_ready_i ? MEM : (class_q == CL_ST) ? FETCH : WB;
            end
            WB: begin
                rw = 1'b1;
                m2r = class_q == CL_LD;
                done = 1'b1;
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase
        // a ready in the expiring cycle takes precedence over the timeout
        wait_mem = req && !mem_ready_i;
        tmo_hit = wait_mem && (tcnt_q + 1'b1 == TIMEOUT_W'(TIMEOUT_CYCLES));
        tcnt_d = wait_mem ? tcnt_q + 1'b1 : '0;
        timeout_d = timeout_q | tmo_hit;
        if (tmo_hit) state_d = HALT;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= FETCH;
            class_q <= CL_R;
            tcnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            tcnt_q <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign mem_req_o    = rst_ni & req;
    assign mem_we_o     = rst_ni & we;
    assign ir_write_o   = rst_ni & irw;
    assign pc_write_o   = rst_ni & pcw;
    assign pc_src_o     = rst_ni & pcs;
    assign alu_src_o    = rst_ni & alus;
    assign alu_op_o     = rst_ni ? aluop : 2'b00;
    assign mem_to_reg_o = rst_ni & m2r;
    assign reg_write_o  = rst_ni & rw;
    assign instr_done_o = rst_ni & done;
    assign illegal_o    = rst_ni & ill;
    assign timeout_o    = rst_ni & timeout_q;
    assign halted_o     = rst_ni & (state_q == HALT);
    assign state_o      = rst_ni ? state_q : 3'd0;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) instret_q <= '0;
        else if (done) instret_q <= instret_q + 32'd1;
    end
    assign instret_o = rst_ni ? instret_q : 32'd0;
`else
    assign instret_o = 32'd0;
`endif
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core subset (R-type, lw, sw, beq). It steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB and drives one single-ported memory for both instruction and data access. It sits beside the datapath and replaces the single-cycle decoder as the source of all per-cycle control strobes. Illegal opcodes and memory timeouts park the core in HALT.

Parameters:
TIMEOUT_CYCLES, 16, maximum consecutive cycles mem_req_o may stay high without mem_ready_i before a timeout
TIMEOUT_W, 5, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk_i  in  1  single clock; all state changes on rising edge
rst_ni  in  1  synchronous, active-low reset
opcode_i  in  7  opcode field of instruction register; valid from DECODE onward
zero_i  in  1  ALU zero flag; sampled in EXEC of beq
mem_ready_i  in  1  memory completes current access this cycle
mem_req_o  out  1  memory access request
mem_we_o  out  1  1 = write (sw), 0 = read
ir_write_o  out  1  load instruction register from memory read data
pc_write_o  out  1  update PC
pc_src_o  out  1  0 = PC+4, 1 = branch target
alu_src_o  out  1  0 = rs2, 1 = immediate
alu_op_o  out  2  00 add, 01 sub/compare, 10 funct-decoded
mem_to_reg_o  out  1  writeback selects memory data
reg_write_o  out  1  register file write enable
instr_done_o  out  1  one-cycle pulse at instruction retirement
illegal_o  out  1  one-cycle pulse on illegal opcode
timeout_o  out  1  sticky; set on memory timeout, cleared only by reset
halted_o  out  1  high while in HALT
state_o  out  3  current state encoding, debug only
instret_o  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- States/encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are unreachable and go to HALT.
- Reset: while rst_ni=0 at a clock edge, state<=FETCH, class register<=0, timeout counter<=0, timeout_o<=0, instret<=0.
- While rst_ni is low, all outputs are combinationally forced to 0.
- Outputs are combinational from state, the registered instruction class, mem_ready_i and zero_i. Strobes not listed below are 0.
- FETCH: mem_req_o=1, mem_we_o=0.
  - When mem_ready_i=1: ir_write_o=1, pc_write_o=1, pc_src_o=0, next state DECODE.
  - Otherwise remain in FETCH.
- DECODE: opcode_i is classified and the class is registered (R=0110011, LD=0000011, ST=0100011, BR=1100011).
  - Valid class: next state EXEC.
  - Any other opcode: illegal_o=1 this cycle, next state HALT.
- EXEC:
  - R: alu_op_o=10, alu_src_o=0, next state WB.
  - LD/ST: alu_op_o=00, alu_src_o=1, next state MEM.
  - BR: alu_op_o=01, alu_src_o=0. If zero_i=1 then pc_write_o=1, pc_src_o=1. In both cases instr_done_o=1 and next state FETCH. reg_write_o stays 0.
- MEM: mem_req_o=1, mem_we_o=(class==ST), alu_src_o=1, alu_op_o=00.
  - On mem_ready_i: ST retires (instr_done_o=1, next state FETCH); LD goes to WB.
  - Otherwise remain in MEM.
- WB: reg_write_o=1, mem_to_reg_o=(class==LD), instr_done_o=1, next state FETCH.
- Latency with zero wait states: R=4 cycles, lw=5, sw=4, beq=3.
- Timeout:
  - The counter increments each cycle mem_req_o=1 and mem_ready_i=0, and clears on any other cycle.
  - When it would reach TIMEOUT_CYCLES: timeout_o<=1, next state HALT.
  - mem_ready_i=1 in that same cycle wins: normal transition, no timeout.
- HALT: all strobes 0 and halted_o=1. The only exit is reset.
- opcode_i is ignored outside DECODE; changes in later states have no effect.

Optional Feature:
MULTICYCLE_CTRL_INSTRET_EN
- Defined: instret_o is a 32-bit counter, +1 on each instr_done_o pulse. It wraps from 0xFFFFFFFF to 0, resets to 0 and holds in HALT.
- Undefined: no counter logic; instret_o is tied to 0.

Test Plan:
- Reset, then add (0110011) with mem_ready_i=1 every cycle -> state sequence 0,1,2,4,0; reg_write_o=1 only in WB; instr_done_o pulses once, cycle 4 after reset release.
- lw with ready delayed 3 cycles in MEM -> MEM held 4 cycles, mem_we_o=0 throughout; WB mem_to_reg_o=1; total 8 cycles.
- beq with zero_i=1, then zero_i=0 -> first: pc_write_o=1, pc_src_o=1 in EXEC; second: pc_write_o=0; neither asserts reg_write_o.
- opcode 1111111 in DECODE -> illegal_o single pulse; halted_o=1 from next cycle; mem_req_o=0 until rst_ni low for one edge, then FETCH.
- mem_ready_i held 0 in FETCH with TIMEOUT_CYCLES=16 -> HALT after 16 requesting cycles with timeout_o=1; repeat with ready on the 16th cycle -> no timeout, DECODE entered.
- With MULTICYCLE_CTRL_INSTRET_EN: 5 instructions (add, lw, sw, beq, add) -> instret_o=5. Without the macro -> instret_o=0.
